// File: rtl/pre_mem_stage_if.sv
// Data-port bundle between the pre-memory stage and the data SRAM-like bus.
// The stage drives the request fields. The memory side returns the accept strobe.
interface pre_mem_stage_if;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;

    modport master (
        output data_sram_req,
        output data_sram_wr,
        output data_sram_size,
        output data_sram_addr,
        output data_sram_wstrb,
        output data_sram_wdata,
        input  data_sram_addr_ok
    );

    modport slave (
        input  data_sram_req,
        input  data_sram_wr,
        input  data_sram_size,
        input  data_sram_addr,
        input  data_sram_wstrb,
        input  data_sram_wdata,
        output data_sram_addr_ok
    );
endinterface

// File: rtl/pre_mem_stage.sv
// Dual-issue pre-memory stage.
// The stage captures an instruction pair from execute and checks load/store alignment for each slot.
// It issues up to two in-order data requests on one port and commits HI/LO when the pair moves on.
// It forwards the payload plus per-slot exception/issue status to the memory stage.
module pre_mem_stage #(
    parameter int PAYLOAD_WD = 512
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    es_to_pms_valid,
    output logic                    pms_allowin,
    input  logic [PAYLOAD_WD-1:0]   es_payload,
    input  logic                    i1_except_in,
    input  logic                    i2_except_in,
    input  logic [4:0]              i1_exccode_in,
    input  logic [4:0]              i2_exccode_in,
    input  logic                    i2_valid,
    input  logic                    i1_load,
    input  logic                    i1_store,
    input  logic                    i2_load,
    input  logic                    i2_store,
    input  logic [1:0]              i1_size,
    input  logic [1:0]              i2_size,
    input  logic [31:0]             i1_addr,
    input  logic [31:0]             i2_addr,
    input  logic [31:0]             i1_wdata,
    input  logic [31:0]             i2_wdata,
    input  logic                    i1_hi_we,
    input  logic                    i1_lo_we,
    input  logic                    i2_hi_we,
    input  logic                    i2_lo_we,
    input  logic [1:0]              i1_hl_src,
    input  logic [1:0]              i2_hl_src,
    input  logic [31:0]             i1_rs,
    input  logic [31:0]             i2_rs,
    input  logic [63:0]             i1_mul,
    input  logic [63:0]             i2_mul,
    input  logic [63:0]             i1_div,
    input  logic [63:0]             i2_div,
    input  logic                    clear_all,
    pre_mem_stage_if.master         dsram,
    input  logic                    ms_allowin,
    output logic                    pms_to_ms_valid,
    output logic [PAYLOAD_WD+15:0]  pms_to_ms_bus,
    output logic                    pms_drop_resp,
    output logic [31:0]             hi_out,
    output logic [31:0]             lo_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ1 = 2'd1,
        ST_REQ2 = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic        except;
        logic [4:0]  exccode;
        logic        load;
        logic        store;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        hi_we;
        logic        lo_we;
        logic [1:0]  hl_src;
        logic [31:0] rs;
        logic [63:0] mul;
        logic [63:0] div;
    } slot_t;

    // ---------------------------------------------------------------
    // Per-slot helpers
    // ---------------------------------------------------------------
    function automatic logic mem_op_f(input slot_t s);
        return s.load || s.store;
    endfunction

    function automatic logic misaligned_f(input slot_t s);
        logic m;
        case (s.size)
            2'd1:    m = s.addr[0];
            2'd2:    m = (s.addr[1:0] != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    // An upstream exception or an address error on a memory op.
    function automatic logic except_f(input slot_t s);
        return s.except || (mem_op_f(s) && misaligned_f(s));
    endfunction

    // An upstream code keeps priority. Otherwise AdEL (0x04) or AdES (0x05) is reported.
    function automatic logic [4:0] exccode_f(input slot_t s);
        logic [4:0] c;
        if (s.except) begin
            c = s.exccode;
        end else if (mem_op_f(s) && misaligned_f(s)) begin
            c = s.load ? 5'h04 : 5'h05;
        end else begin
            c = 5'h00;
        end
        return c;
    endfunction

    function automatic logic [3:0] wstrb_f(input slot_t s);
        logic [3:0] w;
        if (!s.store) begin
            w = 4'b0000;
        end else begin
            case (s.size)
                2'd0:    w = 4'b0001 << s.addr[1:0];
                2'd1:    w = 4'b0011 << s.addr[1:0];
                default: w = 4'b1111;
            endcase
        end
        return w;
    endfunction

    function automatic logic [31:0] wdata_f(input slot_t s);
        logic [31:0] d;
        case (s.size)
            2'd0:    d = {4{s.wdata[7:0]}};
            2'd1:    d = {2{s.wdata[15:0]}};
            default: d = s.wdata;
        endcase
        return d;
    endfunction

    // Applies one slot's HI/LO write to a {hi, lo} pair.
    function automatic logic [63:0] hilo_apply_f(input slot_t s, input logic [63:0] hilo);
        logic [63:0] src;
        logic [63:0] res;
        case (s.hl_src)
            2'd1:    src = s.mul;
            2'd2:    src = s.div;
            default: src = {s.rs, s.rs};
        endcase
        res[63:32] = s.hi_we ? src[63:32] : hilo[63:32];
        res[31:0]  = s.lo_we ? src[31:0]  : hilo[31:0];
        return res;
    endfunction

    // ---------------------------------------------------------------
    // Storage
    // ---------------------------------------------------------------
    state_e                  state_q, state_d;
    logic                    pms_valid_q, pms_valid_d;
    logic                    drop_q, drop_d;
    logic                    iss1_q, iss1_d;
    logic                    iss2_q, iss2_d;
    logic [31:0]             hi_q, hi_d;
    logic [31:0]             lo_q, lo_d;
    logic [PAYLOAD_WD-1:0]   payload_q;
    slot_t                   s1_q, s2_q;
    logic                    i2_valid_q;

    slot_t                   s1_in_s, s2_in_s;
    logic                    in_need1_s, in_need2_s;
    logic                    exc1_s, exc2_s;
    logic                    need2_cap_s;
    logic                    in_req_s;
    logic                    drop_pend_s;
    logic                    ready_go_s;
    logic                    capture_s;
    logic                    fire_s;
    slot_t                   cur_s;
    logic [63:0]             hilo_s;

    assign s1_in_s = '{except: i1_except_in, exccode: i1_exccode_in, load: i1_load,
                       store: i1_store, size: i1_size, addr: i1_addr, wdata: i1_wdata,
                       hi_we: i1_hi_we, lo_we: i1_lo_we, hl_src: i1_hl_src, rs: i1_rs,
                       mul: i1_mul, div: i1_div};
    assign s2_in_s = '{except: i2_except_in, exccode: i2_exccode_in, load: i2_load,
                       store: i2_store, size: i2_size, addr: i2_addr, wdata: i2_wdata,
                       hi_we: i2_hi_we, lo_we: i2_lo_we, hl_src: i2_hl_src, rs: i2_rs,
                       mul: i2_mul, div: i2_div};

    // Request needs for the incoming pair. They choose the first state at capture.
    assign in_need1_s = mem_op_f(s1_in_s) && !except_f(s1_in_s) && !clear_all;
    assign in_need2_s = i2_valid && mem_op_f(s2_in_s) && !except_f(s2_in_s)
                        && !except_f(s1_in_s) && !clear_all;

    // Status of the held pair. If slot 1 excepts, slot 2 is shadowed.
    assign exc1_s      = except_f(s1_q);
    assign exc2_s      = i2_valid_q && except_f(s2_q);
    assign need2_cap_s = i2_valid_q && mem_op_f(s2_q) && !exc2_s && !exc1_s;

    // ---------------------------------------------------------------
    // Handshake
    // ---------------------------------------------------------------
    assign in_req_s        = (state_q == ST_REQ1) || (state_q == ST_REQ2);
    assign drop_pend_s     = in_req_s && (drop_q || clear_all);
    assign ready_go_s      = (state_q == ST_DONE) || clear_all;
    assign pms_allowin     = drop_pend_s ? 1'b0 : (!pms_valid_q || (ready_go_s && ms_allowin));
    assign capture_s       = es_to_pms_valid && pms_allowin;
    assign pms_to_ms_valid = pms_valid_q && ready_go_s && !clear_all;
    assign fire_s          = pms_to_ms_valid && ms_allowin;
    assign pms_drop_resp   = drop_pend_s && dsram.data_sram_addr_ok;

    // ---------------------------------------------------------------
    // Data port: the request fields come from the held slot. They stay steady until accepted.
    // ---------------------------------------------------------------
    assign cur_s                 = (state_q == ST_REQ2) ? s2_q : s1_q;
    assign dsram.data_sram_req   = in_req_s;
    assign dsram.data_sram_wr    = cur_s.store;
    assign dsram.data_sram_size  = cur_s.size;
    assign dsram.data_sram_addr  = cur_s.addr;
    assign dsram.data_sram_wstrb = wstrb_f(cur_s);
    assign dsram.data_sram_wdata = wdata_f(cur_s);

    assign pms_to_ms_bus = {payload_q,
                            iss2_q, exc2_s, (i2_valid_q ? exccode_f(s2_q) : 5'h00),
                            iss1_q, exc1_s, exccode_f(s1_q),
                            2'b00};

    assign hi_out = hi_q;
    assign lo_out = lo_q;

    // Next state for the request sequencer, the flush bookkeeping and the issue flags.
    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        iss1_d  = iss1_q;
        iss2_d  = iss2_q;
        case (state_q)
            ST_REQ1: begin
                if (dsram.data_sram_addr_ok) begin
                    if (drop_q || clear_all) begin
                        state_d = ST_IDLE;
                        drop_d  = 1'b0;
                    end else begin
                        iss1_d  = 1'b1;
                        state_d = need2_cap_s ? ST_REQ2 : ST_DONE;
                    end
                end else if (clear_all) begin
                    drop_d = 1'b1;
                end else begin
                    state_d = ST_REQ1;
                end
            end
            ST_REQ2: begin
                if (dsram.data_sram_addr_ok) begin
                    if (drop_q || clear_all) begin
                        state_d = ST_IDLE;
                        drop_d  = 1'b0;
                    end else begin
                        iss2_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end else if (clear_all) begin
                    drop_d = 1'b1;
                end else begin
                    state_d = ST_REQ2;
                end
            end
            ST_IDLE, ST_DONE: begin
                if (clear_all) begin
                    state_d = ST_IDLE;
                end else if (capture_s) begin
                    iss1_d = 1'b0;
                    iss2_d = 1'b0;
                    if (in_need1_s) begin
                        state_d = ST_REQ1;
                    end else if (in_need2_s) begin
                        state_d = ST_REQ2;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (fire_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                drop_d  = 1'b0;
            end
        endcase
    end

    // Pair-valid flag. A flush wins over a capture and over a hand-off.
    always_comb begin
        pms_valid_d = pms_valid_q;
        if (clear_all) begin
            pms_valid_d = 1'b0;
        end else if (capture_s) begin
            pms_valid_d = 1'b1;
        end else if (fire_s) begin
            pms_valid_d = 1'b0;
        end else begin
            pms_valid_d = pms_valid_q;
        end
    end

    // HI/LO commit on hand-off. Slot 1 is applied first, then slot 2, so slot 2 wins.
    always_comb begin
        hilo_s = {hi_q, lo_q};
        if (fire_s) begin
            if (!exc1_s) begin
                hilo_s = hilo_apply_f(s1_q, hilo_s);
            end else begin
                hilo_s = {hi_q, lo_q};
            end
            if (i2_valid_q && !exc1_s && !exc2_s) begin
                hilo_s = hilo_apply_f(s2_q, hilo_s);
            end else begin
                hilo_s = hilo_s;
            end
        end else begin
            hilo_s = {hi_q, lo_q};
        end
        hi_d = hilo_s[63:32];
        lo_d = hilo_s[31:0];
    end

    // Control and architectural state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pms_valid_q <= 1'b0;
            drop_q      <= 1'b0;
            iss1_q      <= 1'b0;
            iss2_q      <= 1'b0;
            hi_q        <= 32'h0000_0000;
            lo_q        <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            pms_valid_q <= pms_valid_d;
            drop_q      <= drop_d;
            iss1_q      <= iss1_d;
            iss2_q      <= iss2_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    // Pair capture registers. Their contents matter only while the pair is valid.
    always_ff @(posedge clk) begin
        if (capture_s) begin
            payload_q  <= es_payload;
            s1_q       <= s1_in_s;
            s2_q       <= s2_in_s;
            i2_valid_q <= i2_valid;
        end
    end

endmodule
